mcpu_prog_loader: RTL

Hardware program loader and verifier for the MCPU instruction RAM. It replaces the bench-side direct memory pokes with a streamed, parametrised path. The block accepts instruction words over a valid/ready stream and writes them to consecutive RAM addresses from 0, with optional pre-clear. It also supports a read-back verify mode and holds the CPU in reset until a clean load completes. It sits between the bench or host stream source and the RAM write/read port, alongside MCPU.

---
 rtl/mcpu_pkg.sv | 26 ++
 rtl/mcpu_prog_loader_if.sv | 24 ++
 rtl/mcpu_prog_cmp.sv | 56 +++++
 rtl/mcpu_prog_loader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared MCPU constants: word geometry, opcodes, loader state and mode encodings.
// Pure declarations; no logic.
package mcpu_pkg;
  localparam int WORD_SIZE    = 16;
  localparam int ADDR_WIDTH   = 8;
  localparam int RAM_SIZE     = 256;
  localparam int OPCODE_SIZE  = 4;
  localparam int OPERAND_SIZE = 4;

  localparam logic [OPCODE_SIZE-1:0] OPC_HALT  = 4'h0;
  localparam logic [OPCODE_SIZE-1:0] OPC_LOAD  = 4'h1;
  localparam logic [OPCODE_SIZE-1:0] OPC_STORE = 4'h2;
  localparam logic [OPCODE_SIZE-1:0] OPC_ADD   = 4'h3;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_VREQ  = 3'd3,
    ST_VCMP  = 3'd4,
    ST_DONE  = 3'd5
  } ldr_state_t;
endpackage

// File: rtl/mcpu_prog_loader_if.sv
// Instruction stream (valid/ready) plus RAM write/read port of the program loader.
// The loader side is the slave modport; the host/RAM side is the master modport.
interface mcpu_prog_loader_if import mcpu_pkg::*; #(
  parameter int WORD_SIZE  = mcpu_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH
);
  logic                  in_valid;
  logic [WORD_SIZE-1:0]  in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic [WORD_SIZE-1:0]  mem_rdata;

  modport master (
    output in_valid, in_data, in_last, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, in_data, in_last, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mcpu_prog_cmp.sv
// Verify datapath: holds the streamed word/last flag, registers the compare against RAM
// read data, and keeps the sticky error flag with the first mismatching address.
module mcpu_prog_cmp import mcpu_pkg::*; #(
  parameter int WORD_SIZE  = mcpu_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_cap_vld,
  input  logic [WORD_SIZE-1:0]  i_cap_dat,
  input  logic                  i_cap_last,
  input  logic                  i_cmp_vld,
  input  logic [WORD_SIZE-1:0]  i_rdata,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_ovf,
  output logic                  o_last,
  output logic                  o_error,
  output logic [ADDR_WIDTH-1:0] o_mismatch_addr
);
  logic [WORD_SIZE-1:0]  r_word;
  logic                  r_last;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_mm_addr;
  logic                  w_mismatch;

  assign w_mismatch = i_cmp_vld && (i_rdata != r_word);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word    <= '0;
      r_last    <= 1'b0;
      r_error   <= 1'b0;
      r_mm_addr <= '0;
    end else begin
      if (i_clear) begin
        r_error   <= 1'b0;
        r_mm_addr <= '0;
      end
      if (i_cap_vld) begin
        r_word <= i_cap_dat;
        r_last <= i_cap_last;
      end
      // error doubles as "first mismatch already seen"; overflow only ever ends the op
      if (w_mismatch && !r_error) begin
        r_error   <= 1'b1;
        r_mm_addr <= i_addr;
      end
      if (i_ovf) r_error <= 1'b1;
    end
  end

  assign o_last          = r_last;
  assign o_error         = r_error;
  assign o_mismatch_addr = r_mm_addr;
endmodule

// File: rtl/mcpu_prog_loader.sv
// Streams instruction words into MCPU RAM from address 0 (optional pre-clear) or verifies them.
// Load writes 1 cycle after each handshake; verify runs 1 word per 2 cycles; cpu_hold drops only on a clean load.
module mcpu_prog_loader import mcpu_pkg::*; #(
  parameter int WORD_SIZE      = mcpu_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH     = mcpu_pkg::ADDR_WIDTH,
  parameter int RAM_SIZE       = mcpu_pkg::RAM_SIZE,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_mode,
  mcpu_prog_loader_if.slave     bus,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_words_count,
  output logic [ADDR_WIDTH-1:0] o_mismatch_addr
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH + 1)'(RAM_SIZE);

  ldr_state_t            r_state, w_next;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_hold;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic                  w_start, w_hs, w_at_end, w_last_flag, w_ovf, w_cap, w_cmp;

  assign w_start  = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_hs     = bus.in_valid && bus.in_ready;
  assign w_at_end = (r_ptr == LAST_ADDR);
  assign w_cap    = (r_state == ST_VREQ) && w_hs;
  assign w_cmp    = (r_state == ST_VCMP);
  assign w_ovf    = w_at_end && (((r_state == ST_LOAD) && w_hs && !bus.in_last) ||
                                 (w_cmp && !w_last_flag));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE:
        if (i_start) begin
          if (i_mode == MODE_VERIFY) w_next = ST_VREQ;
          else                       w_next = CLEAR_ON_START ? ST_CLEAR : ST_LOAD;
        end
      ST_CLEAR: if (w_at_end) w_next = ST_LOAD;
      ST_LOAD:  if (w_hs && (bus.in_last || w_at_end)) w_next = ST_DONE;
      ST_VREQ:  if (w_hs) w_next = ST_VCMP;
      ST_VCMP:  w_next = (w_last_flag || w_at_end) ? ST_DONE : ST_VREQ;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_LOAD, ST_VREQ: begin
        bus.in_ready = 1'b1;
        o_busy       = 1'b1;
      end
      ST_CLEAR, ST_VCMP: o_busy = 1'b1;
      ST_DONE:           o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode  <= MODE_LOAD;
      r_ptr   <= '0;
      r_count <= '0;
      r_hold  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_mode  <= i_mode;
        r_ptr   <= '0;
        r_count <= '0;
        r_addr  <= '0;
        // a verify leaves the hold exactly as the preceding load left it
        if (i_mode == MODE_LOAD) r_hold <= 1'b1;
      end
      case (r_state)
        ST_CLEAR: begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= '0;
          r_ptr   <= w_at_end ? '0 : r_ptr + 1'b1;
        end
        ST_LOAD: if (w_hs) begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= bus.in_data;
          if (!w_at_end) r_ptr <= r_ptr + 1'b1;
          if (r_count != COUNT_MAX) r_count <= r_count + 1'b1;
          if (bus.in_last && r_mode == MODE_LOAD) r_hold <= 1'b0;
        end
        ST_VCMP: begin
          if (r_count != COUNT_MAX) r_count <= r_count + 1'b1;
          // pre-present the next address so read data is ready when VCMP is reached
          if (!(w_last_flag || w_at_end)) begin
            r_ptr  <= r_ptr + 1'b1;
            r_addr <= r_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mcpu_prog_cmp #(
    .WORD_SIZE  (WORD_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmp (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_clear         (w_start),
    .i_cap_vld       (w_cap),
    .i_cap_dat       (bus.in_data),
    .i_cap_last      (bus.in_last),
    .i_cmp_vld       (w_cmp),
    .i_rdata         (bus.mem_rdata),
    .i_addr          (r_ptr),
    .i_ovf           (w_ovf),
    .o_last          (w_last_flag),
    .o_error         (o_error),
    .o_mismatch_addr (o_mismatch_addr)
  );

  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_cpu_hold    = r_hold;
  assign o_words_count = r_count;
endmodule
